// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the register-bank arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        ACK    = 2'd3
    } arb_state_t;

    localparam int REQ_SPI = 0;
    localparam int REQ_I2C = 1;
    localparam int NUM_REQ = 2;

endpackage

// File: rtl/reg_arb_pick.sv
// Winner selection between SPI and I2C requesters; REG_ARB_ROUND_ROBIN_EN selects round robin, else SPI-first priority.
// Latency: combinational.
// Backpressure: none; losers simply stay pending in their requester.
module reg_arb_pick
    import reg_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] elig,
`ifdef REG_ARB_ROUND_ROBIN_EN
    input  logic               ptr,
`endif
    output logic [NUM_REQ-1:0] gnt
);

    always_comb begin
        gnt = '0;
`ifdef REG_ARB_ROUND_ROBIN_EN
        // ptr names the requester that wins a tie
        if (elig[ptr]) begin
            gnt[ptr] = 1'b1;
        end else if (elig[~ptr]) begin
            gnt[~ptr] = 1'b1;
        end
`else
        if (elig[REQ_SPI]) begin
            gnt[REQ_SPI] = 1'b1;
        end else if (elig[REQ_I2C]) begin
            gnt[REQ_I2C] = 1'b1;
        end
`endif
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Arbitrates SPI/I2C single-beat accesses onto the register bank (optional REG_ARB_ROUND_ROBIN_EN).
// Latency: request sampled at edge N -> bank access N+1, ack N+3, back in IDLE N+4.
// Backpressure: requesters hold req until their one-cycle ack; only IDLE samples requests.
module reg_bank_arbiter
    import reg_arb_pkg::*;
#(
    parameter int REG_W    = 8,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arb_en,
    input  logic              sel,
    input  logic              spi_req,
    input  logic              spi_wr_rdn,
    input  logic [REG_W-1:0]  spi_addr,
    input  logic [REG_W-1:0]  spi_wdata,
    output logic              spi_ack,
    output logic [REG_W-1:0]  spi_rdata,
    output logic              spi_err,
    input  logic              i2c_req,
    input  logic              i2c_wr_rdn,
    input  logic [REG_W-1:0]  i2c_addr,
    input  logic [REG_W-1:0]  i2c_wdata,
    output logic              i2c_ack,
    output logic [REG_W-1:0]  i2c_rdata,
    output logic              i2c_err,
    output logic              bank_we,
    output logic              bank_wr_rdn,
    output logic [ADDR_W-1:0] bank_addr,
    output logic [REG_W-1:0]  bank_wdata,
    input  logic [REG_W-1:0]  bank_rdata,
    input  logic              bank_err,
    output logic              busy,
    output logic [1:0]        grant
);

    localparam logic [REG_W:0] ADDR_LIMIT = (REG_W+1)'(NUM_REGS);

    arb_state_t         state;
    arb_state_t         state_nxt;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] win;
    logic [NUM_REQ-1:0] grant_q;
    logic               cap_wr;
    logic [REG_W-1:0]   cap_addr;
    logic [REG_W-1:0]   cap_wdata;
    logic [REG_W-1:0]   rsp_rdata;
    logic               rsp_err;
    logic               in_range;
    logic               in_access;

    // Static mode masks out the requester not named by sel
    always_comb begin
        elig = '0;
        if (arb_en) begin
            elig[REQ_SPI] = spi_req;
            elig[REQ_I2C] = i2c_req;
        end else if (sel) begin
            elig[REQ_I2C] = i2c_req;
        end else begin
            elig[REQ_SPI] = spi_req;
        end
    end

`ifdef REG_ARB_ROUND_ROBIN_EN
    logic rr_ptr;

    reg_arb_pick u_pick (
        .elig (elig),
        .ptr  (rr_ptr),
        .gnt  (win)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 1'(REQ_SPI);
        end else if (state == ACK) begin
            rr_ptr <= grant_q[REQ_SPI] ? 1'(REQ_I2C) : 1'(REQ_SPI);
        end
    end
`else
    reg_arb_pick u_pick (
        .elig (elig),
        .gnt  (win)
    );
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|win) state_nxt = ACCESS;
            ACCESS:  state_nxt = WAIT;
            WAIT:    state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant_q   <= '0;
            cap_wr    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (|win) begin
                        grant_q   <= win;
                        cap_wr    <= win[REQ_I2C] ? i2c_wr_rdn : spi_wr_rdn;
                        cap_addr  <= win[REQ_I2C] ? i2c_addr   : spi_addr;
                        cap_wdata <= win[REQ_I2C] ? i2c_wdata  : spi_wdata;
                    end
                end
                WAIT: begin
                    rsp_rdata <= in_range ? bank_rdata : '0;
                    rsp_err   <= in_range ? bank_err   : 1'b1;
                end
                ACK:     grant_q <= '0;
                default: ;
            endcase
        end
    end

    assign in_range  = {1'b0, cap_addr} < ADDR_LIMIT;
    assign in_access = (state == ACCESS);

    assign bank_we     = in_access & cap_wr & in_range;
    assign bank_wr_rdn = in_access & cap_wr;
    assign bank_addr   = in_access ? cap_addr[ADDR_W-1:0] : '0;
    assign bank_wdata  = in_access ? cap_wdata : '0;

    assign busy  = (state != IDLE);
    assign grant = grant_q;

    assign spi_ack   = (state == ACK) & grant_q[REQ_SPI];
    assign i2c_ack   = (state == ACK) & grant_q[REQ_I2C];
    assign spi_rdata = spi_ack ? rsp_rdata : '0;
    assign spi_err   = spi_ack & rsp_err;
    assign i2c_rdata = i2c_ack ? rsp_rdata : '0;
    assign i2c_err   = i2c_ack & rsp_err;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter; expected sequences follow REG_ARB_ROUND_ROBIN_EN.
module tb_reg_bank_arbiter;

    localparam int REG_W    = 8;
    localparam int NUM_REGS = 16;
    localparam int ADDR_W   = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              arb_en = 1'b1;
    logic              sel = 1'b0;
    logic              spi_req = 1'b0;
    logic              spi_wr_rdn = 1'b0;
    logic [REG_W-1:0]  spi_addr = '0;
    logic [REG_W-1:0]  spi_wdata = '0;
    logic              spi_ack;
    logic [REG_W-1:0]  spi_rdata;
    logic              spi_err;
    logic              i2c_req = 1'b0;
    logic              i2c_wr_rdn = 1'b0;
    logic [REG_W-1:0]  i2c_addr = '0;
    logic [REG_W-1:0]  i2c_wdata = '0;
    logic              i2c_ack;
    logic [REG_W-1:0]  i2c_rdata;
    logic              i2c_err;
    logic              bank_we;
    logic              bank_wr_rdn;
    logic [ADDR_W-1:0] bank_addr;
    logic [REG_W-1:0]  bank_wdata;
    logic [REG_W-1:0]  bank_rdata = '0;
    logic              bank_err = 1'b0;
    logic              busy;
    logic [1:0]        grant;

    int n_cmp = 0;
    int n_bad = 0;

    reg_bank_arbiter #(
        .REG_W    (REG_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .arb_en      (arb_en),
        .sel         (sel),
        .spi_req     (spi_req),
        .spi_wr_rdn  (spi_wr_rdn),
        .spi_addr    (spi_addr),
        .spi_wdata   (spi_wdata),
        .spi_ack     (spi_ack),
        .spi_rdata   (spi_rdata),
        .spi_err     (spi_err),
        .i2c_req     (i2c_req),
        .i2c_wr_rdn  (i2c_wr_rdn),
        .i2c_addr    (i2c_addr),
        .i2c_wdata   (i2c_wdata),
        .i2c_ack     (i2c_ack),
        .i2c_rdata   (i2c_rdata),
        .i2c_err     (i2c_err),
        .bank_we     (bank_we),
        .bank_wr_rdn (bank_wr_rdn),
        .bank_addr   (bank_addr),
        .bank_wdata  (bank_wdata),
        .bank_rdata  (bank_rdata),
        .bank_err    (bank_err),
        .busy        (busy),
        .grant       (grant)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated transaction; port 0 = SPI, 1 = I2C
    task automatic xact(input bit port, input bit wr, input logic [7:0] addr,
                        input logic [7:0] wdata, input logic [7:0] rd_val, input bit rd_err,
                        input bit exp_we, input logic [7:0] exp_rdata, input bit exp_err);
        if (port == 1'b0) begin
            spi_req = 1'b1; spi_wr_rdn = wr; spi_addr = addr; spi_wdata = wdata;
        end else begin
            i2c_req = 1'b1; i2c_wr_rdn = wr; i2c_addr = addr; i2c_wdata = wdata;
        end
        tick();
        check_val("access_we", bank_we, exp_we);
        check_val("access_grant", grant, port ? 2'b10 : 2'b01);
        check_val("access_busy", busy, 1);
        if (addr < NUM_REGS) begin
            check_val("access_addr", bank_addr, addr[3:0]);
            if (wr) check_val("access_wdata", bank_wdata, wdata);
        end
        tick();
        check_val("wait_we", bank_we, 0);
        check_val("wait_addr", bank_addr, 0);
        check_val("wait_ack", spi_ack | i2c_ack, 0);
        bank_rdata = rd_val;
        bank_err   = rd_err;
        tick();
        bank_rdata = '0;
        bank_err   = 1'b0;
        check_val("ack_spi", spi_ack, port == 1'b0);
        check_val("ack_i2c", i2c_ack, port == 1'b1);
        check_val("ack_rdata", port ? i2c_rdata : spi_rdata, exp_rdata);
        check_val("ack_err", port ? i2c_err : spi_err, exp_err);
        check_val("ack_other_rdata", port ? spi_rdata : i2c_rdata, 0);
        check_val("ack_we", bank_we, 0);
        spi_req = 1'b0;
        i2c_req = 1'b0;
        tick();
        check_val("post_busy", busy, 0);
        check_val("post_ack", spi_ack | i2c_ack, 0);
    endtask

    logic [1:0] exp_seq [4];
    int cyc;
    int n_spi;
    int n_i2c;

    initial begin
`ifdef REG_ARB_ROUND_ROBIN_EN
        exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
`else
        exp_seq[0] = 2'b01; exp_seq[1] = 2'b01; exp_seq[2] = 2'b01; exp_seq[3] = 2'b01;
`endif
        tick();
        tick();
        check_val("rst_busy", busy, 0);
        check_val("rst_grant", grant, 0);
        check_val("rst_acks", {spi_ack, i2c_ack}, 0);
        check_val("rst_bank", {bank_we, bank_wr_rdn, bank_addr, bank_wdata}, 0);
        check_val("rst_rdata", {spi_rdata, i2c_rdata, spi_err, i2c_err}, 0);
        rst = 1'b0;
        tick();

        xact(1'b0, 1'b1, 8'h03, 8'hA5, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
        xact(1'b1, 1'b0, 8'h09, 8'h00, 8'h5C, 1'b0, 1'b0, 8'h5C, 1'b0);
        xact(1'b0, 1'b0, 8'h40, 8'h00, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b1);
        xact(1'b1, 1'b0, 8'h0F, 8'h00, 8'h33, 1'b1, 1'b0, 8'h33, 1'b1);
        xact(1'b1, 1'b1, 8'h10, 8'h77, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);

        // Contention with both requests held for four transactions
        spi_req = 1'b1; spi_wr_rdn = 1'b0; spi_addr = 8'h01;
        i2c_req = 1'b1; i2c_wr_rdn = 1'b0; i2c_addr = 8'h02;
        for (int k = 0; k < 4; k++) begin
            cyc = 0;
            do begin
                tick();
                cyc++;
            end while (!(spi_ack || i2c_ack) && cyc < 8);
            check_val($sformatf("cont_lat%0d", k), cyc, (k == 0) ? 3 : 4);
            check_val($sformatf("cont_who%0d", k), {i2c_ack, spi_ack}, exp_seq[k]);
        end
        spi_req = 1'b0;
        i2c_req = 1'b0;
        tick();
        check_val("cont_idle", busy, 0);

        // Static mode: only the selected requester is served
        arb_en = 1'b0; sel = 1'b1;
        spi_req = 1'b1; i2c_req = 1'b1;
        n_spi = 0;
        n_i2c = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (spi_ack) n_spi++;
            if (i2c_ack) n_i2c++;
        end
        check_val("static_spi_acks", n_spi, 0);
        check_val("static_i2c_acks", n_i2c, 2);
        spi_req = 1'b0; i2c_req = 1'b0;
        tick();
        sel = 1'b0;
        i2c_req = 1'b1;
        tick(); tick(); tick();
        check_val("static_ignore_busy", busy, 0);
        check_val("static_ignore_ack", i2c_ack, 0);
        i2c_req = 1'b0;
        arb_en = 1'b1;
        tick();

        // Reset landing in WAIT aborts the transaction
        spi_req = 1'b1; spi_wr_rdn = 1'b0; spi_addr = 8'h04;
        tick();
        tick();
        check_val("mid_busy", busy, 1);
        rst = 1'b1;
        spi_req = 1'b0;
        tick();
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_ack", spi_ack, 0);
        check_val("mid_rst_grant", grant, 0);
        check_val("mid_rst_we", bank_we, 0);
        rst = 1'b0;
        tick();
        check_val("mid_post_ack", spi_ack, 0);
        xact(1'b0, 1'b1, 8'h02, 8'h3C, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
